// File: rtl/lsu_pkg.sv
// Shared types for the DMEM load/store unit: FSM states, latched request record, byte-lane geometry.
package lsu_pkg;
  localparam int LSU_DATA_W = 32;
  localparam int LSU_ADDR_W = 32;
  localparam int LANES      = 4;
  localparam int LANE_W     = 8;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, DONE} lsu_state_e;

  // "byte" is a keyword, so the byte-access flag is is_byte.
  typedef struct packed {
    logic                  write;
    logic                  is_byte;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] wdata;
  } lsu_req_t;
endpackage

// File: rtl/byte_lane_merge.sv
// Little-endian byte lane helper: extracts a zero-extended lane from a word and
// builds the word with that lane replaced (used for the byte-store read-modify-write).
module byte_lane_merge
  import lsu_pkg::*;
(
  input  logic [LSU_DATA_W-1:0] word,
  input  logic [1:0]            lane,
  input  logic [LANE_W-1:0]     byte_in,
  output logic [LSU_DATA_W-1:0] extracted,
  output logic [LSU_DATA_W-1:0] merged
);
  always_comb begin
    extracted = '0;
    merged    = word;
    for (int i = 0; i < LANES; i++) begin
      if (lane == i[1:0]) begin
        extracted[LANE_W-1:0]      = word[i*LANE_W +: LANE_W];
        merged[i*LANE_W +: LANE_W] = byte_in;
      end
    end
  end
endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-wide DMEM: word/byte loads and stores, byte stores via RMW.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned word accesses (rsp_err) instead of forcing alignment.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [IDX_W-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata
);
  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and rsp_valid pulses for one cycle in DONE.
  lsu_state_e        state;
  lsu_req_t          req_q;
  logic              rsp_err_q;
  logic              misaligned;
  logic [DATA_W-1:0] lane_byte;
  logic [DATA_W-1:0] merged_word;
  logic              unused_addr_bits;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = !req_byte && (req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign req_ready        = (state == IDLE);
  assign rsp_err          = rsp_err_q;
  assign unused_addr_bits = ^req_q.addr[ADDR_W-1:2];

  byte_lane_merge u_lane (
    .word      (mem_rdata),
    .lane      (req_q.addr[1:0]),
    .byte_in   (req_q.wdata[LANE_W-1:0]),
    .extracted (lane_byte),
    .merged    (merged_word)
  );

  // Outputs are registered on entry to each state, so mem_wen is high exactly
  // during ACCESS (word store) or MERGE and drops at once on async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err_q <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q <= '{write: req_write, is_byte: req_byte, addr: req_addr, wdata: req_wdata};
            if (misaligned) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_err_q <= 1'b1;
            end else begin
              state    <= ACCESS;
              mem_addr <= req_addr[IDX_W+1:2];
              if (req_write && !req_byte) begin
                mem_wen   <= 1'b1;
                mem_wdata <= req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (req_q.write && req_q.is_byte) begin
            mem_wdata <= merged_word;
            mem_wen   <= 1'b1;
            state     <= MERGE;
          end else begin
            mem_wen <= 1'b0;
            if (!req_q.write) rsp_data <= req_q.is_byte ? lane_byte : mem_rdata;
            rsp_valid <= 1'b1;
            rsp_err_q <= 1'b0;
            state     <= DONE;
          end
        end
        MERGE: begin
          mem_wen   <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err_q <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          rsp_valid <= 1'b0;
          rsp_err_q <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a 64-word DMEM model (combinational read, write on rising clk).
module tb_dmem_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_byte = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_wen;
  logic [31:0] rsp_data, mem_wdata, mem_rdata;
  logic [5:0]  mem_addr;

  logic [31:0] mem [64] = '{default: 32'h0};
  logic        pre_en = 1'b0;
  logic [5:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  int          checks = 0;
  int          errors = 0;
  int          wen_count = 0;
  logic [5:0]  wen_addr_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  dmem_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wen) begin
      mem[mem_addr] <= mem_wdata;
      wen_count++;
      wen_addr_q.push_back(mem_addr);
    end else if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // One request; checks ready, busy, latency (accept edge to rsp_valid), err and pulse width.
  task automatic do_req(input string tag, input logic w, input logic b, input logic [31:0] a,
                        input logic [31:0] d, input int exp_lat, input logic exp_err);
    int n;
    @(negedge clk);
    check({tag, "_ready"}, req_ready, 1);
    req_valid = 1'b1; req_write = w; req_byte = b; req_addr = a; req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    if (!rsp_valid) check({tag, "_busy"}, req_ready, 0);
    n = 1;
    while (!rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_err"}, rsp_err, exp_err);
    @(negedge clk);
    check({tag, "_pulse"}, rsp_valid, 0);
  endtask

  logic [31:0] ldrb_exp [4] = '{32'hDD, 32'hCC, 32'h11, 32'hAA};
  logic        b2b_w [3]    = '{1'b0, 1'b1, 1'b0};
  logic [31:0] b2b_a [3]    = '{32'h24, 32'h28, 32'h28};
  logic [31:0] b2b_d [3]    = '{32'h0, 32'h1234_5678, 32'h0};
  logic        trap;

  initial begin
    int k, resp, cyc;
    int acc [3];
`ifdef LSU_MISALIGN_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;

    // Word stores then load
    do_req("str20", 1, 0, 32'h20, 32'h0000_01FF, 2, 0);
    do_req("str24", 1, 0, 32'h24, 32'h0000_0067, 2, 0);
    check("wen_count_str", wen_count, 2);
    check("wen_addr0", wen_addr_q.size() > 0 ? wen_addr_q[0] : 6'h3F, 8);
    check("wen_addr1", wen_addr_q.size() > 1 ? wen_addr_q[1] : 6'h3F, 9);
    check("mem9", mem[9], 32'h67);
    do_req("ldr20", 0, 0, 32'h20, 32'h0, 2, 0);
    check("ldr20_data", rsp_data, 32'h0000_01FF);
    check("wen_count_ldr", wen_count, 2);

    // Byte store read-modify-write; upper wdata bits must be ignored
    preload(8, 32'hAABB_CCDD);
    wen_count = 0;
    do_req("strb22", 1, 1, 32'h22, 32'hFFFF_FF11, 3, 0);
    check("strb_mem8", mem[8], 32'hAA11_CCDD);
    check("strb_wen_once", wen_count, 1);
    check("store_keeps_rsp_data", rsp_data, 32'h0000_01FF);

    // Byte loads across all lanes
    for (int i = 0; i < 4; i++) begin
      do_req("ldrb", 0, 1, 32'h20 + i, 32'h0, 2, 0);
      check("ldrb_data", rsp_data, ldrb_exp[i]);
    end

    // Index wrap: upper address bits ignored
    do_req("ldr_wrap", 0, 0, 32'h0000_0120, 32'h0, 2, 0);
    check("ldr_wrap_data", rsp_data, 32'hAA11_CCDD);
    do_req("str_top", 1, 0, 32'hF000_00FC, 32'h5A5A_0001, 2, 0);
    check("mem63", mem[63], 32'h5A5A_0001);

    // Back-to-back with req_valid held; next request is presented while busy
    exp_q.push_back(32'h67);
    exp_q.push_back(32'h67);
    exp_q.push_back(32'h1234_5678);
    k = 0; resp = 0; cyc = 0;
    for (int t = 0; t < 40 && resp < 3; t++) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        if (exp_q.size() == 0) check("b2b_extra_rsp", 1, 0);
        else check("b2b_data", rsp_data, exp_q.pop_front());
        resp++;
      end
      if (k < 3) begin
        req_valid = 1'b1; req_write = b2b_w[k]; req_byte = 1'b0;
        req_addr = b2b_a[k]; req_wdata = b2b_d[k];
        if (req_ready) begin
          acc[k] = cyc;
          k++;
        end
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b_resp_count", resp, 3);
    check("b2b_accept_count", k, 3);
    check("b2b_gap01", acc[1] - acc[0], 3);
    check("b2b_gap12", acc[2] - acc[1], 3);
    check("b2b_exp_q_empty", exp_q.size(), 0);

    // Reset while in MERGE
    preload(10, 32'h5566_7788);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1; req_addr = 32'h29; req_wdata = 32'h99;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("merge_wen", mem_wen, 1);
    #1 rst_n = 1'b0;
    #1 check("rst_async_wen", mem_wen, 0);
    repeat (2) @(negedge clk);
    check("rst_mem10", mem[10], 32'h5566_7788);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_ready", req_ready, 1);
    check("rst_rel_rsp_valid", rsp_valid, 0);

    // Misaligned word accesses; byte accesses never trap
    do_req("ldr24", 0, 0, 32'h24, 32'h0, 2, 0);
    check("ldr24_data", rsp_data, 32'h67);
    wen_count = 0;
    do_req("ldr21", 0, 0, 32'h21, 32'h0, trap ? 1 : 2, trap);
    check("ldr21_data", rsp_data, trap ? 32'h67 : 32'hAA11_CCDD);
    check("ldr21_no_wen", wen_count, 0);
    do_req("ldrb21", 0, 1, 32'h21, 32'h0, 2, 0);
    check("ldrb21_data", rsp_data, 32'hCC);
    do_req("str2d", 1, 0, 32'h2D, 32'hCAFE_F00D, trap ? 1 : 2, trap);
    check("str2d_mem11", mem[11], trap ? 32'h0 : 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
